uart_frame_decoder: RTL and testbench

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_frame_decoder_if.sv | 8 +
 rtl/uart_frame_decoder.sv | 153 +++++++++++++++
 tb/tb_uart_frame_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_decoder_if.sv
// rtl/uart_frame_decoder_if.sv - UART receiver byte handoff into the frame decoder
interface uart_frame_decoder_if;
  logic       rec_readyH;
  logic [7:0] rec_dataH;

  modport master (output rec_readyH, output rec_dataH);
  modport slave  (input  rec_readyH, input  rec_dataH);
endinterface

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - sync-framed UART light-box decoder; CHECKSUM_EN adds an XOR check byte
// Outputs change only on a complete frame; stalled frames are dropped after TIMEOUT_CYCLES.
module uart_frame_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_l,
  uart_frame_decoder_if.slave        rx,
  output logic [3:0]                 box_1,
  output logic [3:0]                 box_2,
  output logic [3:0]                 box_3,
  output logic [7:0]                 leds,
  output logic                       frame_ok,
  output logic                       frame_err
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_MAX   = {CNT_W{1'b1}};

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, B1, B2, B3, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;
`endif

  state_t           state;
  state_t           state_nx;
  logic             rdy_q;
  logic             strobe;
  logic             timeout;
  logic             commit;
  logic             abort;
  logic [CNT_W-1:0] gap_cnt;
  logic [7:0]       sh_b1;
  logic [7:0]       commit_leds;
`ifdef CHECKSUM_EN
  logic [7:0]       sh_b2;
  logic [7:0]       sh_leds;
`else
  logic [3:0]       sh_b2;
`endif

  assign strobe  = rx.rec_readyH & ~rdy_q;
  // A strobe on the limit cycle clears the counter, so it must also mask the timeout.
  assign timeout = (state != IDLE) && !strobe && (gap_cnt == GAP_LIMIT);

`ifdef CHECKSUM_EN
  assign commit_leds = sh_leds;
`else
  assign commit_leds = rx.rec_dataH;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (strobe && rx.rec_dataH == SYNC_BYTE) state_nx = B1;
      B1:   if (strobe) state_nx = B2;
      B2:   if (strobe) state_nx = B3;
`ifdef CHECKSUM_EN
      B3:   if (strobe) state_nx = CHK;
      CHK:  if (strobe) state_nx = IDLE;
`else
      B3:   if (strobe) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
    if (timeout) state_nx = IDLE;
  end

  always_comb begin
    commit = 1'b0;
    abort  = 1'b0;
    case (state)
`ifdef CHECKSUM_EN
      CHK: begin
        commit = strobe && (rx.rec_dataH == (sh_b1 ^ sh_b2 ^ sh_leds));
        abort  = strobe && (rx.rec_dataH != (sh_b1 ^ sh_b2 ^ sh_leds));
      end
`else
      B3: commit = strobe;
`endif
      default: ;
    endcase
    if (timeout) abort = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rdy_q     <= 1'b0;
      gap_cnt   <= '0;
      sh_b1     <= '0;
      sh_b2     <= '0;
`ifdef CHECKSUM_EN
      sh_leds   <= '0;
`endif
      box_1     <= '0;
      box_2     <= '0;
      box_3     <= '0;
      leds      <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rdy_q     <= rx.rec_readyH;
      frame_ok  <= commit;
      frame_err <= abort;

      if (state == IDLE || strobe) begin
        gap_cnt <= '0;
      end else if (gap_cnt != GAP_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (strobe) begin
        case (state)
          B1: sh_b1 <= rx.rec_dataH;
`ifdef CHECKSUM_EN
          B2: sh_b2   <= rx.rec_dataH;
          B3: sh_leds <= rx.rec_dataH;
`else
          B2: sh_b2 <= rx.rec_dataH[3:0];
`endif
          default: ;
        endcase
      end

      if (timeout) begin
        sh_b1   <= '0;
        sh_b2   <= '0;
`ifdef CHECKSUM_EN
        sh_leds <= '0;
`endif
      end

      if (commit) begin
        box_1 <= sh_b1[3:0];
        box_2 <= sh_b1[7:4];
        box_3 <= sh_b2[3:0];
        leds  <= commit_leds;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - randomized frame stimulus against a byte-level frame model
module tb_uart_frame_decoder;
  localparam int         TMO  = 1200;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef CHECKSUM_EN
  localparam int NBODY = 4;
`else
  localparam int NBODY = 3;
`endif

  logic       sys_clk   = 1'b0;
  logic       sys_rst_l = 1'b0;
  logic [3:0] box_1, box_2, box_3;
  logic [7:0] leds;
  logic       frame_ok, frame_err;

  uart_frame_decoder_if rx ();

  uart_frame_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(SYNC)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .rx        (rx.slave),
    .box_1     (box_1),
    .box_2     (box_2),
    .box_3     (box_3),
    .leds      (leds),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int ok_seen  = 0;
  int err_seen = 0;
  always @(negedge sys_clk) begin
    if (frame_ok === 1'b1) ok_seen++;
    if (frame_err === 1'b1) err_seen++;
    check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
  end

  // Byte-level model: a frame is SYNC followed by NBODY bytes, each no more than TMO cycles apart.
  bit         m_in_frame = 1'b0;
  logic [7:0] m_frm[$];
  int         m_last = 0;
  int         exp_ok = 0;
  int         exp_err = 0;
  logic [3:0] e_b1 = '0, e_b2 = '0, e_b3 = '0;
  logic [7:0] e_leds = '0;

  function automatic void model_advance(input int now);
    if (m_in_frame && (now - m_last) > TMO) begin
      m_in_frame = 1'b0;
      exp_err++;
    end
  endfunction

  task automatic model_strobe(input logic [7:0] b, input int k, output bit p_ok, output bit p_err);
    logic [7:0] f0, f1, f2;
    bit         good;
    model_advance(k);
    p_ok   = 1'b0;
    p_err  = 1'b0;
    m_last = k;
    if (!m_in_frame) begin
      if (b == SYNC) begin
        m_in_frame = 1'b1;
        m_frm.delete();
      end
    end else begin
      m_frm.push_back(b);
      if (m_frm.size() == NBODY) begin
        m_in_frame = 1'b0;
        f0 = m_frm[0];
        f1 = m_frm[1];
        f2 = m_frm[2];
        good = 1'b1;
`ifdef CHECKSUM_EN
        good = (m_frm[3] == (f0 ^ f1 ^ f2));
`endif
        if (good) begin
          p_ok = 1'b1;
          exp_ok++;
          e_b1   = f0[3:0];
          e_b2   = f0[7:4];
          e_b3   = f1[3:0];
          e_leds = f2;
        end else begin
          p_err = 1'b1;
          exp_err++;
        end
      end
    end
  endtask

  // Next strobe lands 'pre' cycles after the previous byte's hold ends.
  task automatic send_byte(input logic [7:0] b, input int pre, input int hold);
    bit p_ok, p_err;
    repeat (pre) @(posedge sys_clk);
    #1;
    rx.rec_dataH  = b;
    rx.rec_readyH = 1'b1;
    model_strobe(b, cyc, p_ok, p_err);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("frame_ok_after_strobe", 32'(frame_ok), 32'(p_ok));
    check("frame_err_after_strobe", 32'(frame_err), 32'(p_err));
    if (hold > 1) begin
      repeat (hold - 1) @(posedge sys_clk);
      #1;
    end
    rx.rec_readyH = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] ck, input int pre);
    send_byte(SYNC, pre, 1);
    send_byte(b1, 1, 1);
    send_byte(b2, 2, 1);
    send_byte(b3, 1, 2);
`ifdef CHECKSUM_EN
    send_byte(ck, 1, 1);
`else
    if (ck != 8'h00) send_byte(ck, 0, 0);
`endif
  endtask

  task automatic check_outputs(input string tag);
    @(negedge sys_clk);
    #1;
    model_advance(cyc);
    check({tag, ".box_1"}, 32'(box_1), 32'(e_b1));
    check({tag, ".box_2"}, 32'(box_2), 32'(e_b2));
    check({tag, ".box_3"}, 32'(box_3), 32'(e_b3));
    check({tag, ".leds"}, 32'(leds), 32'(e_leds));
    check({tag, ".ok_count"}, 32'(ok_seen), 32'(exp_ok));
    check({tag, ".err_count"}, 32'(err_seen), 32'(exp_err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".box_1"}, 32'(box_1), 32'd0);
    check({tag, ".box_2"}, 32'(box_2), 32'd0);
    check({tag, ".box_3"}, 32'(box_3), 32'd0);
    check({tag, ".leds"}, 32'(leds), 32'd0);
    check({tag, ".frame_ok"}, 32'(frame_ok), 32'd0);
    check({tag, ".frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 90000", cyc);
    $fatal(1);
  end

  initial begin
    int         prev_hold, pre, hold, last;
    logic [7:0] b[4];
    logic [7:0] ck;

    rx.rec_readyH = 1'b0;
    rx.rec_dataH  = 8'h00;
    #1;
    check_zero("reset_state");
    repeat (3) @(negedge sys_clk);
    sys_rst_l = 1'b1;

    // Basic frame with 100-cycle lead-in.
    send_frame(8'h21, 8'h03, 8'hF0, 8'hD2, 100);
    check_outputs("basic");
    check("basic.box_1_const", 32'(box_1), 32'h1);
    check("basic.leds_const", 32'(leds), 32'hF0);

`ifdef CHECKSUM_EN
    send_frame(8'h44, 8'h55, 8'h66, 8'h00, 3);
    check_outputs("bad_checksum");
    send_frame(8'h9C, 8'h0E, 8'h3B, 8'h9C ^ 8'h0E ^ 8'h3B, 3);
    check_outputs("after_bad_checksum");
`endif

    // Stalled frame: timeout pulse on the exact cycle, then stray byte ignored.
    send_byte(SYNC, 3, 1);
    send_byte(8'h21, 2, 1);
    last = m_last;
    for (int i = 0; i < 2 * TMO && cyc < last + TMO; i++) @(negedge sys_clk);
    check("timeout.before", 32'(frame_err), 32'd0);
    @(negedge sys_clk);
    check("timeout.pulse", 32'(frame_err), 32'd1);
    check_outputs("timeout");
    send_byte(8'h21, 2, 1);
    send_frame(8'h12, 8'h07, 8'h3C, 8'h12 ^ 8'h07 ^ 8'h3C, 2);
    check_outputs("after_timeout");

    // Byte arriving exactly on the limit cycle is accepted.
    send_byte(SYNC, 2, 1);
    send_byte(8'h65, TMO - 1, 1);
    send_byte(8'h0A, 1, 1);
    send_byte(8'h81, 1, 1);
`ifdef CHECKSUM_EN
    send_byte(8'h65 ^ 8'h0A ^ 8'h81, 1, 1);
`endif
    check_outputs("limit_strobe");

    // Sync held high for 1000 cycles is a single strobe.
    send_byte(SYNC, 2, 1000);
    send_byte(8'hB7, 1, 1);
    send_byte(8'h05, 1, 1);
    send_byte(8'h5A, 1, 1);
`ifdef CHECKSUM_EN
    send_byte(8'hB7 ^ 8'h05 ^ 8'h5A, 1, 1);
`endif
    check_outputs("held_ready");

    // Asynchronous reset mid-frame.
    send_byte(SYNC, 2, 1);
    send_byte(8'h21, 1, 1);
    send_byte(8'h03, 1, 1);
    #2;
    sys_rst_l = 1'b0;
    #1;
    check_zero("async_reset");
    m_in_frame = 1'b0;
    e_b1 = '0; e_b2 = '0; e_b3 = '0; e_leds = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    send_frame(8'h21, 8'h03, 8'hF0, 8'hD2, 2);
    check_outputs("after_reset");

    // Randomized traffic: stray bytes, sync-valued data, bad checksums, gaps around the limit.
    prev_hold = 1;
    for (int f = 0; f < 30; f++) begin
      for (int j = 0; j < 4; j++) b[j] = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
      ck = b[0] ^ b[1] ^ b[2];
      if ($urandom_range(0, 4) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      b[3] = ck;
      if ($urandom_range(0, 2) == 0) begin
        send_byte(8'($urandom), $urandom_range(1, 4), prev_hold);
        prev_hold = 1;
      end
      for (int j = -1; j < NBODY; j++) begin
        hold = $urandom_range(1, 3);
        pre  = $urandom_range(1, 4);
        if ($urandom_range(0, 24) == 0) pre = TMO - prev_hold + $urandom_range(0, 1);
        send_byte((j < 0) ? SYNC : b[j], pre, hold);
        prev_hold = hold;
      end
      check_outputs("random");
    end

    repeat (TMO + 5) @(negedge sys_clk);
    check_outputs("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
